mem_port_arbiter: RTL and testbench

Sequencer for the single shared instruction/data memory behind the pipeline. Arbitrates fetch requests from the IF stage against load/store requests from the MEM stage, drives a variable-latency single-port RAM with a req/ready handshake, and generates the freeze signals that stall each stage until its access completes. Cancels in-flight fetches when a branch is taken, so stale instructions never reach the pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_starve_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Imported by the arbiter top and its starvation counter.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF      = 32;
   localparam int DATA_W_DEF      = 32;
   localparam int MAX_IF_WAIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      IF_BUSY,
      MEM_BUSY,
      IF_DROP
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of MEM grants taken while a fetch was waiting.
// Cleared when the fetch finally wins; sat forces the next IF grant.
module mem_port_arbiter_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX = MAX_IF_WAIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int W = $clog2(MAX + 2);

   logic [W-1:0] cnt;

   assign sat = (cnt == W'(MAX));

   // count skipped fetch opportunities, hold at the limit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer: arbitrates IF fetches against MEM
// loads/stores, drives the RAM handshake, and cancels stale fetches.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              branch_taken,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_data,
   output logic              if_freeze,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_freeze,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic              ram_ready,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_t state;
   arb_state_t state_nxt;

   logic mem_any;
   logic skip_sat;
   logic grant_if;
   logic grant_mem;
   logic if_fin;
   logic mem_fin;

   assign mem_any    = mem_rd | mem_wr;
   assign if_freeze  = if_req & ~if_valid;
   assign mem_freeze = mem_any & ~mem_done;

   mem_port_arbiter_starve_counter #(
      .MAX (MAX_IF_WAIT)
   ) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (grant_mem & if_req),
      .clr (grant_if),
      .sat (skip_sat)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // grant decision, completion detection and next state
   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      if_fin    = 1'b0;
      mem_fin   = 1'b0;
      unique case (state)
         IDLE: begin
            if (if_req && (!mem_any || skip_sat)) begin
               grant_if  = 1'b1;
               state_nxt = IF_BUSY;
            end else if (mem_any) begin
               grant_mem = 1'b1;
               state_nxt = MEM_BUSY;
            end
         end
         IF_BUSY: begin
            if (ram_ready) begin
               if_fin    = ~branch_taken;
               state_nxt = IDLE;
            end else if (branch_taken) begin
               state_nxt = IF_DROP;
            end
         end
         MEM_BUSY: begin
            if (ram_ready) begin
               mem_fin   = 1'b1;
               state_nxt = IDLE;
            end
         end
         IF_DROP: begin
            if (ram_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM request side and registered result/pulse outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_valid  <= 1'b0;
         if_data   <= '0;
         mem_done  <= 1'b0;
         mem_rdata <= '0;
      end else begin
         if_valid <= if_fin;
         mem_done <= mem_fin;
         if (if_fin) begin
            if_data <= ram_rdata;
         end
         if (mem_fin && !ram_we) begin
            mem_rdata <= ram_rdata;
         end
         if (grant_if) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= if_addr;
         end else if (grant_mem) begin
            ram_req   <= 1'b1;
            ram_we    <= mem_wr;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
         end else if (ram_ready) begin
            ram_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal checks,
// then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int MAXW = 4;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        branch_taken;
   logic        if_valid;
   logic [31:0] if_data;
   logic        if_freeze;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        mem_freeze;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_ready;
   logic [31:0] ram_rdata;

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MAX_IF_WAIT (MAXW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .branch_taken (branch_taken),
      .if_valid     (if_valid),
      .if_data      (if_data),
      .if_freeze    (if_freeze),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_done     (mem_done),
      .mem_rdata    (mem_rdata),
      .mem_freeze   (mem_freeze),
      .ram_req      (ram_req),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_ready    (ram_ready),
      .ram_rdata    (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: one outstanding access described as a record
   bit          m_busy;
   bit          m_is_if;
   bit          m_drop;
   bit          m_we;
   bit          m_load;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   bit          m_ivalid;
   logic [31:0] m_idata;
   bit          m_mdone;
   logic [31:0] m_mrdata;
   int          m_skip;
   int          wcnt;

   // bench RAM behaviour
   int          fixed_wait;
   bit          use_fixed_rdata;
   logic [31:0] fixed_rdata;

   // random requester state
   bit          if_pend;
   bit          mem_pend;
   logic [31:0] pc;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy   = 0;
      m_is_if  = 0;
      m_drop   = 0;
      m_we     = 0;
      m_load   = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_ivalid = 0;
      m_idata  = '0;
      m_mdone  = 0;
      m_mrdata = '0;
      m_skip   = 0;
      wcnt     = 0;
   endtask

   task automatic model_step();
      bit n_iv;
      bit n_md;
      bit mem_any;
      n_iv = 0;
      n_md = 0;
      mem_any = mem_rd | mem_wr;
      if (!m_busy) begin
         if (if_req && (!mem_any || m_skip == MAXW)) begin
            m_busy  = 1;
            m_is_if = 1;
            m_drop  = 0;
            m_we    = 0;
            m_addr  = if_addr;
            m_skip  = 0;
         end else if (mem_any) begin
            m_busy  = 1;
            m_is_if = 0;
            m_we    = mem_wr;
            m_addr  = mem_addr;
            m_wdata = mem_wdata;
            if (if_req && m_skip < MAXW) m_skip++;
         end
         if (m_busy)
            wcnt = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
      end else begin
         if (m_is_if && branch_taken) m_drop = 1;
         if (ram_ready) begin
            m_busy = 0;
            if (m_is_if && !m_drop) begin
               n_iv    = 1;
               m_idata = ram_rdata;
            end
            if (!m_is_if) begin
               n_md   = 1;
               m_load = !m_we;
               if (!m_we) m_mrdata = ram_rdata;
            end
         end else begin
            wcnt--;
         end
      end
      m_ivalid = n_iv;
      m_mdone  = n_md;
   endtask

   task automatic check_all();
      chk("ram_req", ram_req, m_busy);
      if (m_busy) begin
         chk("ram_addr", ram_addr, m_addr);
         chk("ram_we", ram_we, m_we);
         if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
      end
      chk("if_valid", if_valid, m_ivalid);
      chk("if_data", if_data, m_idata);
      chk("mem_done", mem_done, m_mdone);
      if (m_mdone && m_load) chk("mem_rdata", mem_rdata, m_mrdata);
      chk("if_freeze", if_freeze, if_req & ~m_ivalid);
      chk("mem_freeze", mem_freeze, (mem_rd | mem_wr) & ~m_mdone);
   endtask

   // one clock: RAM answers, compare, advance model, next negedge
   task automatic cycle();
      ram_ready = m_busy && (wcnt == 0);
      ram_rdata = use_fixed_rdata ? fixed_rdata : $urandom;
      #1;
      check_all();
      model_step();
      @(negedge clk);
   endtask

   task automatic drive_random();
      int r;
      if (m_ivalid) begin
         if_pend = 0;
         pc = pc + 32'd4;
      end
      if (m_mdone) mem_pend = 0;
      if (!if_pend) if_pend = ($urandom_range(0, 3) != 0);
      if_req = if_pend;
      branch_taken = ($urandom_range(0, 7) == 0);
      if (branch_taken) pc = $urandom & 32'hFFFF_FFFC;
      if_addr = pc;
      if (!mem_pend) begin
         r = int'($urandom_range(0, 3));
         mem_rd    = (r == 1) || (r == 3);
         mem_wr    = (r == 2) || (r == 3);
         mem_addr  = $urandom & 32'hFFFF_FFFC;
         mem_wdata = $urandom;
         mem_pend  = (r != 0);
      end
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (if_valid !== 1'b1 && n < 10) begin
         n++;
         cycle();
      end
      chk(name, if_valid, 1);
   endtask

   initial begin
      int n;
      rst = 0;
      if_req = 0;
      if_addr = '0;
      branch_taken = 0;
      mem_rd = 0;
      mem_wr = 0;
      mem_addr = '0;
      mem_wdata = '0;
      ram_ready = 0;
      ram_rdata = '0;
      fixed_wait = 0;
      use_fixed_rdata = 0;
      fixed_rdata = '0;
      if_pend = 0;
      mem_pend = 0;
      pc = 32'h1000;
      model_reset();

      @(negedge clk);
      #1;
      chk("rst_ram_req", ram_req, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_mem_done", mem_done, 0);
      chk("rst_if_data", if_data, 0);
      chk("rst_ram_addr", ram_addr, 0);
      @(negedge clk);
      rst = 1;

      // single zero-wait fetch
      fixed_wait = 0;
      use_fixed_rdata = 1;
      fixed_rdata = 32'hE3A00014;
      if_req = 1;
      if_addr = 32'h10;
      cycle();
      chk("t1_req_on", ram_req, 1);
      chk("t1_addr", ram_addr, 32'h10);
      cycle();
      chk("t1_req_off", ram_req, 0);
      chk("t1_valid", if_valid, 1);
      chk("t1_data", if_data, 32'hE3A00014);
      if_req = 0;
      cycle();
      chk("t1_pulse", if_valid, 0);

      // load with three wait states
      fixed_wait = 3;
      fixed_rdata = 32'h1234_5678;
      mem_rd = 1;
      mem_addr = 32'h40;
      cycle();
      n = 0;
      while (ram_req === 1'b1 && n < 10) begin
         chk("t2_we", ram_we, 0);
         chk("t2_freeze", mem_freeze, 1);
         n++;
         cycle();
      end
      chk("t2_req_cycles", n, 4);
      chk("t2_done", mem_done, 1);
      chk("t2_rdata", mem_rdata, 32'h1234_5678);
      chk("t2_freeze_off", mem_freeze, 0);
      mem_rd = 0;
      cycle();
      chk("t2_done_pulse", mem_done, 0);

      // simultaneous fetch and store: store first
      fixed_wait = 0;
      use_fixed_rdata = 0;
      if_req = 1;
      if_addr = 32'h100;
      mem_wr = 1;
      mem_addr = 32'h200;
      mem_wdata = 32'hDEAD_BEEF;
      cycle();
      chk("t3_we", ram_we, 1);
      chk("t3_addr", ram_addr, 32'h200);
      chk("t3_wdata", ram_wdata, 32'hDEAD_BEEF);
      cycle();
      chk("t3_done", mem_done, 1);
      mem_wr = 0;
      cycle();
      chk("t3_if_req", ram_req, 1);
      chk("t3_if_addr", ram_addr, 32'h100);
      chk("t3_if_we", ram_we, 0);
      cycle();
      chk("t3_if_valid", if_valid, 1);
      if_req = 0;
      cycle();

      // starvation limit: four loads, then the fetch is forced
      if_req = 1;
      if_addr = 32'h300;
      mem_rd = 1;
      mem_addr = 32'h1000;
      for (int g = 0; g < 4; g++) begin
         cycle();
         chk("t4_mem_grant", ram_addr, 32'h1000 + 32'(g * 4));
         cycle();
         mem_addr = mem_addr + 32'd4;
      end
      cycle();
      chk("t4_if_forced", ram_addr, 32'h300);
      cycle();
      chk("t4_if_valid", if_valid, 1);
      if_addr = 32'h304;
      cycle();
      chk("t4_skip_cleared", ram_addr, 32'h1010);
      cycle();
      mem_rd = 0;
      cycle();
      chk("t4_if_next", ram_addr, 32'h304);
      cycle();
      if_req = 0;
      cycle();

      // branch during a two-wait-state fetch
      fixed_wait = 2;
      if_req = 1;
      if_addr = 32'h500;
      cycle();
      branch_taken = 1;
      if_addr = 32'h800;
      cycle();
      branch_taken = 0;
      n = 0;
      while (ram_req === 1'b1 && n < 10) begin
         chk("t5_no_valid", if_valid, 0);
         n++;
         cycle();
      end
      chk("t5_no_valid_end", if_valid, 0);
      cycle();
      chk("t5_new_addr", ram_addr, 32'h800);
      wait_valid("t5_refetch_valid");
      if_req = 0;
      cycle();

      // branch coincident with ram_ready
      if_req = 1;
      if_addr = 32'h900;
      cycle();
      n = 0;
      while (!(m_busy && wcnt == 0) && n < 10) begin
         n++;
         cycle();
      end
      branch_taken = 1;
      if_addr = 32'hA00;
      cycle();
      branch_taken = 0;
      chk("t6_no_valid", if_valid, 0);
      chk("t6_req_off", ram_req, 0);
      cycle();
      chk("t6_req_on", ram_req, 1);
      chk("t6_new_addr", ram_addr, 32'hA00);
      wait_valid("t6_refetch_valid");
      if_req = 0;
      cycle();

      // reset in the middle of a load
      fixed_wait = 3;
      mem_rd = 1;
      mem_addr = 32'h40;
      cycle();
      cycle();
      #2;
      rst = 0;
      #1;
      chk("t7_req", ram_req, 0);
      chk("t7_we", ram_we, 0);
      chk("t7_done", mem_done, 0);
      chk("t7_addr", ram_addr, 0);
      chk("t7_if_data", if_data, 0);
      chk("t7_rdata", mem_rdata, 0);
      model_reset();
      mem_rd = 0;
      ram_ready = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      fixed_wait = 0;
      mem_wr = 1;
      mem_addr = 32'h44;
      mem_wdata = 32'h5;
      cycle();
      chk("t7_regrant", ram_req, 1);
      chk("t7_regrant_addr", ram_addr, 32'h44);
      cycle();
      chk("t7_regrant_done", mem_done, 1);
      mem_wr = 0;
      cycle();

      // random traffic
      fixed_wait = -1;
      use_fixed_rdata = 0;
      if_pend = 0;
      mem_pend = 0;
      repeat (3000) begin
         drive_random();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
